// File: rtl/if_fetch.sv
// Instruction fetch: reads a 32-bit word from byte-wide synchronous memory and hands {pc, inst, valid} to IF/ID.
// Define IF_ICACHE_EN to add a direct-mapped one-word-per-line instruction cache of ICACHE_LINES lines.
module if_fetch #(
    parameter int ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_byte_i,
    output logic        stallreq_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    typedef enum logic [2:0] {S_B0, S_B1, S_B2, S_B3, S_L, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic        cache_hit;
    logic [31:0] cache_word;
    logic        unused_ok;

`ifdef IF_ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] line_vld_q;
    logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
    logic [31:0]             data_q [ICACHE_LINES];
    logic [IDX_W-1:0]        rd_idx, wr_idx;
    logic                    fill_en;

    assign rd_idx     = pc_i[IDX_W+1:2];
    assign wr_idx     = fetch_pc_q[IDX_W+1:2];
    assign cache_word = data_q[rd_idx];
    // Only word-aligned PCs use the cache: the line holds the aligned word, not a misaligned byte window.
    assign cache_hit  = (state_q == S_B0) && (pc_i[1:0] == 2'b00) && line_vld_q[rd_idx]
                        && (tag_q[rd_idx] == pc_i[31:IDX_W+2]);
    assign fill_en    = (state_q == S_L) && !flush_i && (fetch_pc_q[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_vld_q <= '0;
        end else if (fill_en) begin
            line_vld_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[wr_idx]  <= fetch_pc_q[31:IDX_W+2];
            data_q[wr_idx] <= {mem_byte_i, buf_q};
        end
    end

    assign unused_ok = ^{stall_i[5:2], stall_i[0]};
`else
    assign cache_hit  = 1'b0;
    assign cache_word = '0;
    assign unused_ok  = ^{stall_i[5:2], stall_i[0], ICACHE_LINES > 0};
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        buf_d      = buf_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        if (flush_i) begin
            state_d    = S_B0;
            buf_d      = '0;
            if_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_B0: begin
                    fetch_pc_d = pc_i;
                    if (cache_hit) begin
                        if_pc_d    = pc_i;
                        if_inst_d  = cache_word;
                        if_valid_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_B1;
                    end
                end
                S_B1: begin
                    buf_d[7:0] = mem_byte_i;
                    state_d    = S_B2;
                end
                S_B2: begin
                    buf_d[15:8] = mem_byte_i;
                    state_d     = S_B3;
                end
                S_B3: begin
                    buf_d[23:16] = mem_byte_i;
                    state_d      = S_L;
                end
                S_L: begin
                    if_inst_d  = {mem_byte_i, buf_q};
                    if_pc_d    = fetch_pc_q;
                    if_valid_d = 1'b1;
                    state_d    = S_DONE;
                end
                S_DONE: begin
                    if (!stall_i[1]) begin
                        if_valid_d = 1'b0;
                        state_d    = S_B0;
                    end
                end
                default: state_d = S_B0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_B0;
            fetch_pc_q <= '0;
            buf_q      <= '0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            buf_q      <= buf_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    // Address phase follows the current state so each byte returns exactly when its capture state runs.
    always_comb begin
        mem_rd_o   = 1'b0;
        mem_addr_o = '0;
        if (!rst) begin
            case (state_q)
                S_B0: if (!cache_hit) begin
                    mem_rd_o   = 1'b1;
                    mem_addr_o = pc_i;
                end
                S_B1: begin
                    mem_rd_o   = 1'b1;
                    mem_addr_o = fetch_pc_q + 32'd1;
                end
                S_B2: begin
                    mem_rd_o   = 1'b1;
                    mem_addr_o = fetch_pc_q + 32'd2;
                end
                S_B3: begin
                    mem_rd_o   = 1'b1;
                    mem_addr_o = fetch_pc_q + 32'd3;
                end
                default: ;
            endcase
        end
    end

    assign stallreq_o = !rst && (state_q != S_DONE) && !flush_i;
    assign if_pc_o    = if_pc_q;
    assign if_inst_o  = if_inst_q;
    assign if_valid_o = if_valid_q;

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly downstream of the PC register.
- Takes the current PC and reads the 32-bit instruction from a byte-wide synchronous instruction memory, four bytes in sequence.
- Assembles the bytes little-endian and presents {pc, inst, valid} to the IF/ID pipeline register.
- Raises a stall request while a fetch is in progress, so the stall controller holds the PC; aborts cleanly on a taken branch.

Parameters:
- ICACHE_LINES, 64, number of direct-mapped one-word lines (power of 2, ≥2); used only when IF_ICACHE_EN is defined.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- pc_i  input  32  current PC from the PC register
- stall_i  input  6  pipeline stall vector; bit 1 = IF/ID hold
- flush_i  input  1  taken branch (ex or id) this cycle
- mem_rd_o  output  1  memory read strobe
- mem_addr_o  output  32  byte address
- mem_byte_i  input  8  read data; valid the cycle after a strobed address
- stallreq_o  output  1  request to stall PC/IF
- if_pc_o  output  32  PC of the delivered instruction
- if_inst_o  output  32  delivered instruction
- if_valid_o  output  1  if_pc_o/if_inst_o valid

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous, active-high.
- Reset values:
  - state = S_B0, fetch_pc = 0, byte buffer = 0.
  - if_pc_o = 0, if_inst_o = 0, if_valid_o = 0, mem_rd_o = 0, mem_addr_o = 0.
  - Reset mid-fetch discards all partial data.
- FSM states: S_B0, S_B1, S_B2, S_B3, S_L, S_DONE.
- S_B0:
  - mem_rd_o = 1, mem_addr_o = pc_i.
  - fetch_pc <= pc_i; next state S_B1.
- S_Bk (k = 1..3):
  - mem_rd_o = 1, mem_addr_o = fetch_pc + k (32-bit wrap; 0xFFFFFFFF+1 = 0).
  - Capture mem_byte_i as byte k-1; next state S_B(k+1), or S_L after S_B3.
- S_L:
  - mem_rd_o = 0; capture byte 3.
  - if_inst_o <= {b3, b2, b1, b0}, if_pc_o <= fetch_pc, if_valid_o <= 1.
  - Next state S_DONE.
- Latency: S_B0 to if_valid_o high is 5 cycles.
- S_DONE:
  - Holds the outputs.
  - If stall_i[1] = 0: at this edge IF/ID consumes the instruction and the PC register advances. Next state S_B0; if_valid_o <= 0.
  - If stall_i[1] = 1: remain in S_DONE, outputs unchanged.
- stallreq_o (combinational) = (state != S_DONE) && !flush_i.
  - Dropping it on flush lets the PC register load the branch target at the same edge.
- flush_i = 1 in any state:
  - Next state S_B0; if_valid_o <= 0.
  - Partial bytes are discarded; the in-flight byte returned next cycle is ignored.
  - mem_rd_o still follows the current state during the flush cycle.
- flush_i has priority over stall_i.
- Misaligned pc_i (pc_i[1:0] != 0): fetched as-is from the four consecutive bytes; no exception.
- mem_addr_o is 0 whenever mem_rd_o = 0.

Optional Feature:
- Macro: IF_ICACHE_EN.
- When defined, a direct-mapped cache of ICACHE_LINES words is added:
  - index = pc[log2(ICACHE_LINES)+1:2]; tag = remaining upper bits pc[31:log2(ICACHE_LINES)+2].
  - Per-line valid bits are cleared by rst.
- Hit in S_B0 (valid && tag match):
  - No memory read (mem_rd_o = 0); load outputs from the cache; next state S_DONE.
  - Latency is 1 cycle.
  - stallreq_o is still high in that S_B0 cycle.
- Miss: normal 5-cycle fetch; the line is filled at S_L.
- A flush before S_L suppresses the fill.
- Without the macro: no cache storage; every fetch takes 5 cycles; ICACHE_LINES is unused.

Test Plan:
- Reset, memory at 0x0 = 13 05 10 00 → mem_addr_o 0,1,2,3 on consecutive cycles; if_inst_o = 0x00100513, if_pc_o = 0, if_valid_o high 5 cycles after rst release; stallreq_o low only in S_DONE.
- stall_i[1] held high 3 cycles in S_DONE → outputs stable, no mem_rd_o; on release, next fetch issues pc_i = 0x4.
- flush_i pulsed during S_B2 with pc_i changing to 0x80 → stallreq_o low that cycle, if_valid_o stays 0; next cycle mem_addr_o = 0x80; returned bytes from the aborted fetch never appear in if_inst_o.
- pc_i = 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; word assembled correctly.
- rst asserted asynchronously mid-S_B3 → all outputs 0 immediately; after release, fetch restarts from S_B0.
- IF_ICACHE_EN, ICACHE_LINES = 4: fetch 0x10 twice; the second fetch has no mem_rd_o and if_valid_o 1 cycle after S_B0. Then fetch 0x20 (same index, different tag) → miss, full 5-cycle fetch, and the line is replaced.
